// File: rtl/spram_arbiter_pkg.sv
// Shared definitions for the SPRAM data-memory arbiter: default bus widths
// and the encoding of which port owns the read response in flight.
package spram_arbiter_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

endpackage

// File: rtl/spram_arbiter.sv
// Shares the single-port 16K x 16 SPRAM between the rj32 CPU data bus (fixed
// priority) and an auxiliary port that is guaranteed a slot by a starvation counter.
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STARVE = 4
) (
    input  logic              clock,
    input  logic              nreset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wren,
    output logic [3:0]        ram_maskwren,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    logic [3:0]        starveCnt_q, starveCnt_d;
    owner_e            owner_q, owner_d;
    logic [DATA_W-1:0] cpuRdata_q, auxRdata_q;

    logic forceAux;
    logic auxGnt;
    logic cpuGnt;

    // While nreset is low every combinational output toward the RAM and requesters is held at 0.
    always_comb begin
        forceAux = 1'b0;
        auxGnt   = 1'b0;
        cpuGnt   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        ram_wren = 1'b0;
        if (nreset) begin
            forceAux = aux_req && (starveCnt_q == STARVE_LIMIT);
            auxGnt   = aux_req && (!cpu_req || forceAux);
            cpuGnt   = cpu_req && !auxGnt;
            ram_addr = auxGnt ? aux_addr  : cpu_addr;
            ram_din  = auxGnt ? aux_wdata : cpu_wdata;
            ram_wren = (cpuGnt && cpu_we) || (auxGnt && aux_we);
        end
    end

    assign cpu_gnt      = cpuGnt;
    assign aux_gnt      = auxGnt;
    assign cpu_stall    = nreset && cpu_req && !cpuGnt;
    assign ram_maskwren = {4{ram_wren}};

    always_comb begin
        starveCnt_d = starveCnt_q;
        owner_d     = OWN_NONE;
        if (auxGnt || !aux_req) begin
            starveCnt_d = 4'd0;
        end else if (starveCnt_q != STARVE_LIMIT) begin
            starveCnt_d = starveCnt_q + 4'd1;
        end
        if (cpuGnt && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (auxGnt && !aux_we) begin
            owner_d = OWN_AUX;
        end
    end

    // The SPRAM output is valid in the cycle after the access, so the owner's
    // rdata shows ram_dout directly then and is latched for holding afterwards.
    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign aux_rvalid = (owner_q == OWN_AUX);
    assign cpu_rdata  = cpu_rvalid ? ram_dout : cpuRdata_q;
    assign aux_rdata  = aux_rvalid ? ram_dout : auxRdata_q;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            starveCnt_q <= 4'd0;
            owner_q     <= OWN_NONE;
            cpuRdata_q  <= '0;
            auxRdata_q  <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            owner_q     <= owner_d;
            if (owner_q == OWN_CPU) begin
                cpuRdata_q <= ram_dout;
            end
            if (owner_q == OWN_AUX) begin
                auxRdata_q <= ram_dout;
            end
        end
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares the single-port 16K x 16 SPRAM data memory between two requesters.
  - CPU port: the primary requester. It is the data-memory bus of the rj32 core.
  - AUX port: the secondary requester, e.g. a debug loader or a VGA front-panel memory viewer.
- Sits between the requesters and the SB_SPRAM256KA instance in the top level, and drives the RAM address, data and write-enable pins.
- The CPU has fixed priority. A starvation counter guarantees the AUX port a slot within a bounded number of cycles.

Parameters:
- ADDR_W, 14, word address width (16K words).
- DATA_W, 16, data width.
- MAX_STARVE, 4, consecutive denied AUX-request cycles before AUX is forced a slot (range 1..15).

Ports:
- clock  in  1  system clock (clk_12m domain); all state updates on rising edge.
- nreset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational grant; the access occurs this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  one-cycle pulse when cpu_rdata is updated.
- cpu_rdata  out  DATA_W  last CPU read data; held between reads.
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata: same as the CPU equivalents, for the AUX port.
- ram_addr  out  ADDR_W  to SPRAM ADDRESS.
- ram_din  out  DATA_W  to SPRAM DATAIN.
- ram_wren  out  1  to SPRAM WREN.
- ram_maskwren  out  4  to SPRAM MASKWREN; equals {4{ram_wren}}.
- ram_dout  in  DATA_W  from SPRAM DATAOUT; valid on the rising edge after the access cycle.

Behaviour:
- Reset
  - Reset is synchronous: nreset low at a rising edge clears starve_cnt, owner, both rvalid and both rdata registers to 0.
  - While nreset is low, the combinational outputs are forced to 0: cpu_gnt, aux_gnt, cpu_stall, ram_wren, ram_maskwren, ram_addr and ram_din.
- Grant logic (combinational)
  - force_aux = aux_req & (starve_cnt == MAX_STARVE).
  - aux_gnt = aux_req & (~cpu_req | force_aux).
  - cpu_gnt = cpu_req & ~aux_gnt.
  - At most one grant per cycle.
- RAM mux
  - The granted port drives ram_addr, ram_din and ram_wren = gnt & we.
  - When neither port is granted: ram_wren = 0, and address/data hold the CPU values. This is don't-care, but no write occurs.
- Starvation counter (4 bits)
  - Clears to 0 when aux_gnt or ~aux_req.
  - Increments when aux_req & ~aux_gnt.
  - Saturates at MAX_STARVE.
- Read-response pipeline
  - owner register encodes NONE, CPU or AUX. It is set to the granted port only for read grants; write grants and idle cycles set it to NONE.
  - On the next rising edge, the owning port's rdata <= ram_dout and its rvalid pulses high for exactly one cycle.
  - The non-owning port's rdata and rvalid are unchanged (its rvalid = 0).
  - Read latency: grant at cycle N, rdata/rvalid visible in cycle N+1. Back-to-back reads sustain 1 access per cycle.
- Simultaneous events
  - Both ports request and force_aux = 0: CPU wins, starve_cnt increments.
  - Both ports request and force_aux = 1: AUX wins, CPU stalls one cycle, starve_cnt clears.
  - Write followed by a read to the same address: the read returns the new data (the SPRAM is read-after-write coherent across cycles).
- Reset mid-operation: any pending rvalid is dropped and rdata clears. Requesters must re-issue after reset.

Decomposition:
- Shared package holds:
  - owner encoding constants OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_AUX = 2'd2.
  - default ADDR_W/DATA_W.
- No sub-module is needed. The grant logic, counter and response pipeline are inline, in a single module.

Test Plan:
- Reset: hold nreset = 0 for 3 cycles with both req high -> gnts 0, ram_wren 0, rvalid 0, rdata 0.
- CPU only: write 0xBEEF @0x0010, then read @0x0010 -> cpu_gnt every cycle, cpu_rvalid pulses the cycle after the read, cpu_rdata = 0xBEEF, aux outputs idle.
- AUX only: read @0x3FFF after a write of 0x1234 -> aux_gnt immediate, aux_rdata = 0x1234 one cycle later; cpu_rdata unchanged.
- Contention, MAX_STARVE = 4: both ports request reads continuously.
  - CPU is granted 4 cycles, then AUX 1 cycle, and the pattern repeats.
  - cpu_stall is high exactly on every 5th cycle.
  - Each rvalid routes to the correct port.
- Write/read interleave: CPU writes 0xAAAA @5 while AUX reads @5 -> CPU granted, AUX stalled. AUX gets 0xAAAA when granted on a later cycle. ram_maskwren = 4'hF only on the write cycle.
- Mid-operation reset: an AUX read is granted and nreset falls on the next edge -> no aux_rvalid pulse, aux_rdata = 0, starve_cnt = 0.
